fetch_redirect_ctrl: RTL and testbench

- Control-side counterpart of the fetch stage: generates every PC-steering input the fetch stage consumes (jmp, pc_jmp, stall, branch, alu_zero, pc_branch).
- Also produces the pipeline kill signals (flush_id, flush_ex) that keep wrong-path and hazarded instructions out of the machine.
- Sits between ID/EX/MEM and the fetch stage.
- Resolves memory wait, EX branch, ID jump and load-use hazards in one priority order that is consistent with the fetch stage's own jmp > stall > branch ordering.

---
 rtl/fetch_redirect_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Redirect, stall and kill control feeding the fetch stage.
// Optional counters: define REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
  parameter int PC_W       = 16,
  parameter int REG_W      = 5,
  parameter int SHADOW_CYC = 2,
  parameter int MAX_WAIT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_jmp,
  input  logic [PC_W-1:0]  id_jmp_target,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_branch,
  input  logic             ex_alu_zero,
  input  logic [PC_W-1:0]  ex_branch_target,
  input  logic             mem_busy,
  output logic             jmp,
  output logic [PC_W-1:0]  pc_jmp,
  output logic             stall,
  output logic             branch,
  output logic             alu_zero,
  output logic [PC_W-1:0]  pc_branch,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             err_timeout,
  output logic [15:0]      stat_stall_cycles,
  output logic [15:0]      stat_redirects
);

  localparam int SH_W = 3;
  localparam int WC_W = $clog2(MAX_WAIT + 1);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      fsm_q;
  logic [SH_W-1:0] sh_q;
  logic [WC_W-1:0] wc_q;
  logic            k_id_q;
  logic            k_ex_q;
  logic            err_q;

  logic shadow;
  logic kill_id;
  logic kill_ex;
  logic ex_ok;
  logic id_ok;
  logic br_take;
  logic jp;
  logic lu;
  logic hit_rs1;
  logic hit_rs2;
  logic sel_busy;
  logic sel_br;
  logic sel_jp;
  logic sel_lu;

  // Kill bits only matter inside the shadow window.
  assign shadow  = (sh_q != '0);
  assign kill_id = k_id_q & shadow;
  assign kill_ex = k_ex_q & shadow;

  assign ex_ok = ex_valid & ~kill_ex;
  assign id_ok = id_valid & ~kill_id;

  assign hit_rs1 = id_uses_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2 = id_uses_rs2 & (id_rs2 == ex_rd);

  assign br_take = ex_ok & ex_is_branch & ex_alu_zero;
  assign jp      = id_ok & id_is_jmp;
  assign lu      = ex_ok & ex_is_load
                 & (ex_rd != '0)
                 & id_ok & (hit_rs1 | hit_rs2);

  assign sel_busy = mem_busy;
  assign sel_br   = ~mem_busy & br_take;
  assign sel_jp   = ~mem_busy & ~br_take & jp;
  assign sel_lu   = ~mem_busy & ~br_take
                  & ~jp & lu;

  assign pc_jmp    = id_jmp_target;
  assign pc_branch = ex_branch_target;

  always_comb begin
    jmp      = 1'b0;
    stall    = 1'b0;
    branch   = 1'b0;
    alu_zero = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        sel_busy: begin
          stall = 1'b1;
        end
        sel_br: begin
          branch   = 1'b1;
          alu_zero = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end
        sel_jp: begin
          jmp      = 1'b1;
          flush_id = 1'b1;
        end
        sel_lu: begin
          stall    = 1'b1;
          flush_ex = 1'b1;
        end
        default: begin
          jmp = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= RUN;
      wc_q  <= '0;
      err_q <= 1'b0;
    end else if (mem_busy) begin
      fsm_q <= WAIT;
      if (wc_q != WC_W'(MAX_WAIT))
        wc_q <= wc_q + 1'b1;
      if (wc_q >= WC_W'(MAX_WAIT - 1))
        err_q <= 1'b1;
    end else if (fsm_q == WAIT) begin
      fsm_q <= RUN;
      wc_q  <= '0;
    end
  end

  // Shadow and kill state hold still whenever the pipe is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      k_id_q <= 1'b0;
      k_ex_q <= 1'b0;
    end else if (!stall) begin
      if (branch) begin
        sh_q   <= SH_W'(SHADOW_CYC);
        k_id_q <= 1'b1;
        k_ex_q <= 1'b1;
      end else if (jmp) begin
        sh_q   <= SH_W'(SHADOW_CYC);
        k_id_q <= 1'b1;
        k_ex_q <= 1'b0;
      end else begin
        if (shadow)
          sh_q <= sh_q - 1'b1;
        k_ex_q <= k_id_q;
        k_id_q <= 1'b0;
      end
    end
  end

  assign err_timeout = err_q & ~reset;

`ifdef REDIRECT_STATS_EN
  logic [15:0] st_stall_q;
  logic [15:0] st_redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_stall_q <= '0;
      st_redir_q <= '0;
    end else begin
      if (stall && st_stall_q != 16'hFFFF)
        st_stall_q <= st_stall_q + 1'b1;
      if ((branch | jmp) && st_redir_q != 16'hFFFF)
        st_redir_q <= st_redir_q + 1'b1;
    end
  end

  assign stat_stall_cycles = reset ? '0 : st_stall_q;
  assign stat_redirects    = reset ? '0 : st_redir_q;
`else
  assign stat_stall_cycles = '0;
  assign stat_redirects    = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl (MAX_WAIT=4,
// SHADOW_CYC=2).
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_is_jmp;
  logic [15:0] id_jmp_target;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_is_branch;
  logic        ex_alu_zero;
  logic [15:0] ex_branch_target;
  logic        mem_busy;
  logic        jmp;
  logic [15:0] pc_jmp;
  logic        stall;
  logic        branch;
  logic        alu_zero;
  logic [15:0] pc_branch;
  logic        flush_id;
  logic        flush_ex;
  logic        err_timeout;
  logic [15:0] stat_stall_cycles;
  logic [15:0] stat_redirects;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(
    .PC_W(16), .REG_W(5),
    .SHADOW_CYC(2), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid),
    .id_is_jmp(id_is_jmp),
    .id_jmp_target(id_jmp_target),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid),
    .ex_is_load(ex_is_load),
    .ex_rd(ex_rd),
    .ex_is_branch(ex_is_branch),
    .ex_alu_zero(ex_alu_zero),
    .ex_branch_target(ex_branch_target),
    .mem_busy(mem_busy),
    .jmp(jmp), .pc_jmp(pc_jmp),
    .stall(stall), .branch(branch),
    .alu_zero(alu_zero),
    .pc_branch(pc_branch),
    .flush_id(flush_id),
    .flush_ex(flush_ex),
    .err_timeout(err_timeout),
    .stat_stall_cycles(stat_stall_cycles),
    .stat_redirects(stat_redirects)
  );

  // expected bits: {jmp,stall,branch,alu_zero,flush_id,flush_ex,err}
  localparam logic [6:0] J  = 7'b1000000;
  localparam logic [6:0] S  = 7'b0100000;
  localparam logic [6:0] B  = 7'b0010000;
  localparam logic [6:0] Z  = 7'b0001000;
  localparam logic [6:0] FI = 7'b0000100;
  localparam logic [6:0] FE = 7'b0000010;
  localparam logic [6:0] E  = 7'b0000001;
  localparam logic [6:0] N  = 7'b0000000;

  typedef struct {
    string       name;
    logic        rst;
    logic        busy;
    logic        idv;
    logic        ijmp;
    logic [15:0] jt;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        exv;
    logic        ld;
    logic [4:0]  rd;
    logic        br;
    logic        z;
    logic [15:0] bt;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    string nm, logic rst, logic busy,
    logic idv, logic ijmp, logic [15:0] jt,
    logic [4:0] rs1, logic u1,
    logic [4:0] rs2, logic u2,
    logic exv, logic ld, logic [4:0] rd,
    logic br, logic z, logic [15:0] bt,
    logic [6:0] exp);
    vec_t v;
    v.name = nm; v.rst = rst; v.busy = busy;
    v.idv = idv; v.ijmp = ijmp; v.jt = jt;
    v.rs1 = rs1; v.u1 = u1;
    v.rs2 = rs2; v.u2 = u2;
    v.exv = exv; v.ld = ld; v.rd = rd;
    v.br = br; v.z = z; v.bt = bt;
    v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset            = v.rst;
    mem_busy         = v.busy;
    id_valid         = v.idv;
    id_is_jmp        = v.ijmp;
    id_jmp_target    = v.jt;
    id_rs1           = v.rs1;
    id_uses_rs1      = v.u1;
    id_rs2           = v.rs2;
    id_uses_rs2      = v.u2;
    ex_valid         = v.exv;
    ex_is_load       = v.ld;
    ex_rd            = v.rd;
    ex_is_branch     = v.br;
    ex_alu_zero      = v.z;
    ex_branch_target = v.bt;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {jmp, stall, branch, alu_zero,
            flush_id, flush_ex, err_timeout};
  endfunction

  // Apply one vector after the edge, check mid-cycle.
  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    #4;
    chk(v.name, 32'(ctl()), 32'(v.exp));
    chk({v.name, "_pc"}, {pc_jmp, pc_branch},
        {v.jt, v.bt});
  endtask

  task automatic simple(input string nm,
                        input logic rst,
                        input logic busy,
                        input logic [6:0] exp);
    run_vec(mk(nm, rst, busy, 0, 0, 16'h0,
               0, 0, 0, 0, 0, 0, 0, 0, 0,
               16'h0, exp));
  endtask

  task automatic jump(input string nm,
                      input logic rst,
                      input logic [15:0] jt,
                      input logic [6:0] exp);
    run_vec(mk(nm, rst, 0, 1, 1, jt,
               0, 0, 0, 0, 0, 0, 0, 0, 0,
               16'h0, exp));
  endtask

  initial begin
    drive(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, N));
    repeat (2) @(posedge clk);

    tbl.push_back(mk("rst_out", 1, 1, 1, 1, 16'h0100,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0040, N));
    tbl.push_back(mk("idle", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_rs1", 0, 0, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 1, 3, 0, 0, 16'h0, S|FE));
    tbl.push_back(mk("lu_clear", 0, 0, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 0, 3, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_rs2", 0, 0, 1, 0, 16'h0,
      3, 1, 7, 1, 1, 1, 7, 0, 0, 16'h0, S|FE));
    tbl.push_back(mk("lu_x0", 0, 0, 1, 0, 16'h0,
      0, 1, 0, 0, 1, 1, 0, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_nouse", 0, 0, 1, 0, 16'h0,
      5, 0, 0, 0, 1, 1, 5, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_idinv", 0, 0, 0, 0, 16'h0,
      5, 1, 0, 0, 1, 1, 5, 0, 0, 16'h0, N));
    tbl.push_back(mk("br_vs_jmp", 0, 0, 1, 1, 16'h0100,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0040,
      B|Z|FI|FE));
    tbl.push_back(mk("jmp_killed", 0, 0, 1, 1, 16'h0200,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0080, N));
    tbl.push_back(mk("jmp_after", 0, 0, 1, 1, 16'h0300,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0090, J|FI));
    tbl.push_back(mk("jmp_shadow", 0, 0, 1, 1, 16'h0400,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, N));
    tbl.push_back(mk("jmp_honour", 0, 0, 1, 1, 16'h0500,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, J|FI));
    tbl.push_back(mk("br_ntaken", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0020, N));
    tbl.push_back(mk("ex_killed", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0030, N));
    tbl.push_back(mk("br_taken", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0040,
      B|Z|FI|FE));
    tbl.push_back(mk("idle2", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, N));
    tbl.push_back(mk("idle3", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, N));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("busy_br", 0, 1, 0, 0, 16'h0,
        0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0060, S));
    tbl.push_back(mk("busy_br_rel", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 1, 0, 0, 1, 1, 16'h0060,
      B|Z|FI|FE));
    tbl.push_back(mk("lu_killed", 0, 0, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 1, 3, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_ex_kill", 0, 0, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 1, 3, 0, 0, 16'h0, N));
    tbl.push_back(mk("lu_ok", 0, 0, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 1, 3, 0, 0, 16'h0, S|FE));
    tbl.push_back(mk("busy_lu", 0, 1, 1, 0, 16'h0,
      3, 1, 0, 0, 1, 1, 3, 0, 0, 16'h0, S));
    tbl.push_back(mk("idle4", 0, 0, 0, 0, 16'h0,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, N));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Timeout: error appears once four busy edges have passed.
    for (int n = 1; n <= 6; n++)
      simple($sformatf("tmo_busy%0d", n), 0, 1,
             (n >= 5) ? (S | E) : S);
    simple("tmo_sticky", 0, 0, E);
    simple("tmo_sticky2", 0, 0, E);
    simple("tmo_rst", 1, 0, N);
    simple("tmo_clr", 0, 0, N);

    // Reset while waiting and inside a jump shadow.
    jump("pre_jmp", 0, 16'h0700, J|FI);
    simple("wait1", 0, 1, S);
    simple("wait2", 0, 1, S);
    simple("rst_wait", 1, 1, N);
    @(negedge clk);
    chk("stat_stall_rst", 32'(stat_stall_cycles), 0);
    chk("stat_redir_rst", 32'(stat_redirects), 0);
    jump("post_rst_jmp", 0, 16'h0800, J|FI);
    simple("post_busy", 0, 1, S);
    simple("post_idle", 0, 0, N);
    @(negedge clk);
`ifdef REDIRECT_STATS_EN
    chk("stat_stall", 32'(stat_stall_cycles), 1);
    chk("stat_redir", 32'(stat_redirects), 1);
`else
    chk("stat_stall", 32'(stat_stall_cycles), 0);
    chk("stat_redir", 32'(stat_redirects), 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
